// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit index needs at least one bit even when only bit 0 exists.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_seq_if.sv
// Request/result bundle for serial_add_seq; master is the requester, slave the adder.
interface serial_add_seq_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );
endinterface

// File: rtl/fa_bit.sv
// One-bit full adder, purely combinational.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder, one bit per cycle LSB first; done pulses WIDTH edges after an accepted start.
// start is only accepted while ready; requests during RUN/DONE are dropped, not queued.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic             clk,
  input logic             rst,
  serial_add_seq_if.slave bus
);
  localparam int               IDX_W    = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             fa_s, fa_c;

  // Operands are shifted right each cycle so the adder always sees bit 0.
  fa_bit u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_RUN;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        sum_d[idx_q] = fa_s;
        carry_d      = fa_c;
        a_d          = a_q >> 1;
        b_d          = b_q >> 1;
        if (idx_q == LAST_IDX) begin
          cout_d  = fa_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new addition; sampled only when ready=1.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port cin  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port ready  output  1  high only in IDLE.
REQ-009 SHALL have port busy  output  1  high only in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port sum  output  WIDTH  result, registered.
REQ-012 SHALL have port cout  output  1  final carry-out, registered.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; encoding is implementation choice.
REQ-014 SHALL, in IDLE with start=1 at edge k, capture a, b, cin, clear the bit index to 0, and enter RUN.
REQ-015 SHALL, in RUN, process exactly one bit per cycle, LSB first, through a single one-bit full-adder stage: s = a[i] xor b[i] xor c; c_next = majority(a[i], b[i], c).
REQ-016 SHALL write s into sum bit i and update the carry register each RUN cycle; sum bits above i hold their cleared value (0) until written.
REQ-017 SHALL leave RUN for DONE at the edge that processes bit WIDTH-1, i.e. edge k+WIDTH.
REQ-018 SHALL assert done=1 for exactly the cycle spent in DONE, with sum and cout final in that cycle; latency from accepted start to done = WIDTH edges.
REQ-019 SHALL transition DONE -> IDLE unconditionally on the next edge.
REQ-020 SHALL hold sum and cout stable from DONE until the next accepted start, which clears sum to 0.
REQ-021 SHALL ignore start while in RUN or DONE; no queuing.
REQ-022 SHALL, with WIDTH=1, spend exactly one cycle in RUN.
REQ-023 SHALL produce sum/cout equal to (a + b + cin) mod 2^WIDTH and bit WIDTH, respectively, for all operands.

Reset
REQ-024 SHALL, when rst=1 at an edge, enter IDLE with sum=0, cout=0, carry=0, bit index=0, done=0, busy=0; ready=1 from the following cycle.
REQ-025 SHALL give rst priority over start and over any in-progress operation; an aborted addition produces no done pulse.

Structure
REQ-026 SHALL place the FSM state typedef and default WIDTH constant in shared package serial_add_pkg.
REQ-027 SHALL instantiate exactly one combinational sub-module fa_bit (inputs a, b, cin; outputs s, cout) as the per-bit datapath; all sequencing stays in serial_add_seq.
REQ-028 SHALL size the bit index to clog2(WIDTH) bits, minimum 1.

Verification
REQ-029 SHALL verify WIDTH=8: a=0x00, b=0x00, cin=0 -> done at edge k+8, sum=0x00, cout=0.
REQ-030 SHALL verify a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple).
REQ-031 SHALL verify a=0x5A, b=0x35, cin=1 -> sum=0x90, cout=0; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 SHALL verify start pulsed at RUN bit 3 with different operands -> ignored; first result unchanged and only one done pulse.
REQ-033 SHALL verify rst asserted during RUN bit 4 -> next cycle ready=1, sum=0, cout=0, no done; a following start completes normally.
REQ-034 SHALL verify WIDTH=1 exhaustively (all 8 a/b/cin combinations) -> done one edge after start, sum/cout match full-adder truth table.
